csa_cpa_resolve: RTL and testbench

// - Downstream stage of the carry-save adder: converts a redundant (sum, carry) pair into one binary result.
// - Uses a multi-cycle chunked carry-propagate add, CW bits per cycle, to keep the carry chain short.
// - Sits between CSA reduction trees and any consumer that needs a resolved DW-bit value.
// - valid/ready handshake on both sides.

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_chunk_adder.sv | 14 +
 rtl/csa_cpa_resolve.sv | 92 +++++++++
 tb/tb_csa_cpa_resolve.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the chunked carry-propagate resolver.
package csa_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} cpa_state_t;

    function automatic int nchunk(input int dw, input int cw);
        return (cw < 1) ? 1 : dw / cw;
    endfunction

    // A one-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational CW-bit adder with carry in/out; one chunk of the resolver.
module csa_chunk_adder #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/csa_cpa_resolve.sv
// Resolves a carry-save (sum, carry) pair into one binary value, adding CW bits
// per cycle so the carry chain stays one chunk long.
module csa_cpa_resolve
    import csa_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sum,
    input  logic [DW-1:0] in_carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_cout
);

    localparam int NCHUNK = nchunk(DW, CW);
    localparam int IW     = idx_width(NCHUNK);

    generate
        if (CW < 1 || CW > DW || (DW % CW) != 0) begin : g_bad_cfg
            $error("csa_cpa_resolve: CW must divide DW and satisfy 1 <= CW <= DW");
        end
    endgenerate

    cpa_state_t    state, state_nxt;
    logic [DW-1:0] op_s, op_c, res;
    logic [IW-1:0] idx;
    logic          cy;
    logic          cout_q;
    logic          accept;
    logic          last;
    logic [CW-1:0] ch_sum;
    logic          ch_cout;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = (idx == IW'(NCHUNK - 1));
    assign out_valid = (state == DONE);
    assign out_data  = res;
    assign out_cout  = cout_q;

    csa_chunk_adder #(.CW(CW)) u_chunk (
        .a    (op_s[int'(idx)*CW +: CW]),
        .b    (op_c[int'(idx)*CW +: CW]),
        .cin  (cy),
        .sum  (ch_sum),
        .cout (ch_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ADD;
            ADD:  if (last)   state_nxt = DONE;
            // Draining and accepting on the same edge skips IDLE entirely.
            DONE: if (out_ready) state_nxt = in_valid ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_s   <= '0;
            op_c   <= '0;
            res    <= '0;
            idx    <= '0;
            cy     <= 1'b0;
            cout_q <= 1'b0;
        end else if (accept) begin
            op_s <= in_sum;
            op_c <= in_carry;
            idx  <= '0;
            cy   <= 1'b0;
        end else if (state == ADD) begin
            res[int'(idx)*CW +: CW] <= ch_sum;
            cy  <= ch_cout;
            idx <= idx + 1'b1;
            if (last) cout_q <= ch_cout;
        end
    end

endmodule

// File: tb/tb_csa_cpa_resolve.sv
// Directed bench for csa_cpa_resolve: a 32/8 chunked instance and a 16/16 single-chunk one.
module tb_csa_cpa_resolve;
    import csa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_cout;
    logic [31:0] in_sum, in_carry, out_data;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_cout_b;
    logic [15:0] in_sum_b, in_carry_b, out_data_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_cpa_resolve #(.DW(32), .CW(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cout(out_cout)
    );

    csa_cpa_resolve #(.DW(16), .CW(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sum(in_sum_b), .in_carry(in_carry_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_cout(out_cout_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h cout=%b in_ready=%b, want 0/00000000/0/1",
                     out_valid, out_data, out_cout, in_ready);
        end
    endtask

    task automatic test_basic();
        in_sum = 32'h0000_00FF; in_carry = 32'h0000_0002; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_sum = 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (out_valid !== (k == 4)) begin
                errors++;
                $display("FAIL basic_latency cycle %0d: out_valid=%b want %b", k, out_valid, (k == 4));
            end
        end
        checks++;
        if (out_data !== 32'h0000_0101 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_data: got %h/%b want 00000101/0", out_data, out_cout);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_one_cycle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_ripple();
        in_sum = 32'hFFFF_FFFF; in_carry = 32'h0000_0002; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0001 || out_cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple: got v=%b %h/%b want 1 00000001/1", out_valid, out_data, out_cout);
        end
        tick();
    endtask

    task automatic test_backpressure();
        in_sum = 32'h1111_1111; in_carry = 32'h2222_2222; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h3333_3333 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: got v=%b %h/%b want 1 33333333/0", out_valid, out_data, out_cout);
        end
        // Next pair waits upstream while the consumer stalls.
        in_sum = 32'hF000_0000; in_carry = 32'h1000_0000; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h3333_3333 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: v=%b %h/%b in_ready=%b want 1 33333333/0 0",
                         k, out_valid, out_data, out_cout, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_release: in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
        end
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_early: out_valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0000 || out_cout !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got v=%b %h/%b want 1 00000000/1", out_valid, out_data, out_cout);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] s [16];
        logic [31:0] c [16];
        logic [32:0] exp_sum;
        for (int i = 0; i < 16; i++) begin
            s[i] = $urandom;
            c[i] = $urandom;
        end
        s[0] = 32'hFFFF_0000; c[0] = 32'h0001_0000;
        in_sum = s[0]; in_carry = c[0]; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i < 15) begin
                in_sum = s[i+1]; in_carry = c[i+1];
            end else begin
                in_valid = 1'b0;
            end
            for (int k = 1; k <= 3; k++) begin
                tick();
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_gap item %0d cycle %0d: out_valid=%b want 0", i, k, out_valid);
                end
            end
            tick();
            exp_sum = {1'b0, s[i]} + {1'b0, c[i]};
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_sum[31:0] || out_cout !== exp_sum[32]) begin
                errors++;
                $display("FAIL stream item %0d: got v=%b %h/%b want 1 %h/%b",
                         i, out_valid, out_data, out_cout, exp_sum[31:0], exp_sum[32]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        in_sum = 32'hDEAD_BEEF; in_carry = 32'h0101_0101; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: v=%b data=%h in_ready=%b want 0/00000000/1", out_valid, out_data, in_ready);
        end
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ghost: out_valid=%b want 0", out_valid);
        end
        in_sum = 32'h1234_5678; in_carry = 32'h1111_1110; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h2345_6788 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next: got v=%b %h/%b want 1 23456788/0", out_valid, out_data, out_cout);
        end
        tick();
    endtask

    task automatic test_single_chunk();
        in_sum_b = 16'h8000; in_carry_b = 16'h8000; in_valid_b = 1'b1; out_ready_b = 1'b1;
        checks++;
        if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: in_ready=%b out_valid=%b want 1/0", in_ready_b, out_valid_b);
        end
        tick();
        in_valid_b = 1'b0;
        checks++;
        if (out_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: out_valid=%b want 0", out_valid_b);
        end
        tick();
        checks++;
        if (out_valid_b !== 1'b1 || out_data_b !== 16'h0000 || out_cout_b !== 1'b1) begin
            errors++;
            $display("FAIL single_result: got v=%b %h/%b want 1 0000/1", out_valid_b, out_data_b, out_cout_b);
        end
        tick();
        checks++;
        if (out_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: out_valid=%b want 0", out_valid_b);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sum = '0; in_carry = '0; out_ready = 1'b0;
        in_valid_b = 1'b0; in_sum_b = '0; in_carry_b = '0; out_ready_b = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_single_chunk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
